// File: rtl/peripheral_bus_pkg.sv
// peripheral_bus_pkg: shared state encoding and bus width constants for the peripheral bus initiator
package peripheral_bus_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESPOND} state_e;
  localparam int PB_ADDRESS_WIDTH = 24;
  localparam int PB_DATA_WIDTH = 32;
  localparam int PB_SELECT_WIDTH = 4;
  localparam logic [PB_DATA_WIDTH-1:0] PERIPHERAL_BUS_ERROR_DATA = 32'hFFFF_FFFF;
endpackage

// File: rtl/peripheral_bus_timeout.sv
// peripheral_bus_timeout: access-length counter that flags when TIMEOUT_CYCLES has been reached
module peripheral_bus_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : en ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
  assign expired = cnt_q == W'(TIMEOUT_CYCLES);
endmodule

// File: rtl/peripheral_bus_initiator.sv
// peripheral_bus_initiator: bridges single Wishbone-classic transfers onto one peripheral-bus access
module peripheral_bus_initiator
  import peripheral_bus_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = PB_ADDRESS_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wb_cyc_i,
  input  logic                       wb_stb_i,
  input  logic                       wb_we_i,
  input  logic [PB_SELECT_WIDTH-1:0] wb_sel_i,
  input  logic [31:0]                wb_adr_i,
  input  logic [PB_DATA_WIDTH-1:0]   wb_data_i,
  output logic                       wb_ack_o,
  output logic                       wb_error_o,
  output logic [PB_DATA_WIDTH-1:0]   wb_data_o,
  output logic                       peripheralBus_we,
  output logic                       peripheralBus_oe,
  input  logic                       peripheralBus_busy,
  output logic [ADDRESS_WIDTH-1:0]   peripheralBus_address,
  output logic [PB_SELECT_WIDTH-1:0] peripheralBus_byteSelect,
  output logic [PB_DATA_WIDTH-1:0]   peripheralBus_dataWrite,
  input  logic [PB_DATA_WIDTH-1:0]   peripheralBus_dataRead,
  input  logic                       requestOutput
);
  state_e state_q, state_d;
  logic we_q, we_d, oe_q, oe_d, ack_q, ack_d, err_q, err_d;
  logic [ADDRESS_WIDTH-1:0] adr_q, adr_d;
  logic [PB_SELECT_WIDTH-1:0] sel_q, sel_d;
  logic [PB_DATA_WIDTH-1:0] wdat_q, wdat_d, rdat_q, rdat_d;
  logic expired, done, unused_adr;
  assign unused_adr = ^wb_adr_i[31:ADDRESS_WIDTH];
  peripheral_bus_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_q != ST_ACCESS),
    .en      (state_q == ST_ACCESS),
    .expired (expired)
  );
  // An access ends when the responder releases busy or the timeout hits; a master abort wins over both.
  assign done = wb_cyc_i && (!peripheralBus_busy || expired);
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    oe_d    = oe_q;
    adr_d   = adr_q;
    sel_d   = sel_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: if (wb_cyc_i && wb_stb_i) begin
        state_d = ST_ACCESS;
        we_d    = wb_we_i;
        oe_d    = !wb_we_i;
        adr_d   = wb_adr_i[ADDRESS_WIDTH-1:0];
        sel_d   = wb_sel_i;
        wdat_d  = wb_data_i;
      end
      ST_ACCESS: if (!wb_cyc_i || done) begin
        state_d = done ? ST_RESPOND : ST_IDLE;
        we_d    = 1'b0;
        oe_d    = 1'b0;
        ack_d   = done;
        err_d   = done && (peripheralBus_busy || (oe_q && !requestOutput));
        rdat_d  = !(done && oe_q) ? rdat_q :
                  (peripheralBus_busy || !requestOutput) ? PERIPHERAL_BUS_ERROR_DATA :
                  peripheralBus_dataRead;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      oe_q    <= 1'b0;
      adr_q   <= '0;
      sel_q   <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      oe_q    <= oe_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end
  assign wb_ack_o                 = ack_q;
  assign wb_error_o               = err_q;
  assign wb_data_o                = rdat_q;
  assign peripheralBus_we         = we_q;
  assign peripheralBus_oe         = oe_q;
  assign peripheralBus_address    = adr_q;
  assign peripheralBus_byteSelect = sel_q;
  assign peripheralBus_dataWrite  = wdat_q;
endmodule
